// File: rtl/rf_sequencer.sv
// Four-state controller that fetches an instruction, reads two operands from an 8x16 register file,
// runs a simple ALU op and writes the result back. One instruction in flight, 4 cycles per instruction.
module rf_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  rf_rd0_addr,
  output logic [2:0]  rf_rd1_addr,
  input  logic [15:0] rf_rd0_data,
  input  logic [15:0] rf_rd1_data,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic        done,
  output logic        err,
  output logic        flag_z,
  output logic        flag_c,
  output logic [15:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] res_q, res_d;
  logic        nz_q, nz_d;
  logic        nc_q, nc_d;
  logic [15:0] result_q, result_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;

  logic [3:0]  op;
  logic        op_writes;
  logic [16:0] sum17;
  logic [16:0] addi17;
  logic [15:0] alu_res;
  logic        alu_c;

  assign op        = ir_q[15:12];
  assign op_writes = (op != 4'h0) && (op <= 4'hB);
  assign sum17     = {1'b0, opa_q} + {1'b0, opb_q};
  assign addi17    = {1'b0, opa_q} + {1'b0, {{10{ir_q[5]}}, ir_q[5:0]}};

  // alu_c defaults to the current carry so MOV/LI/NOP/illegal leave it untouched
  always_comb begin
    alu_res = 16'h0000;
    alu_c   = flag_c_q;
    case (op)
      4'h1: begin alu_res = sum17[15:0]; alu_c = sum17[16]; end
      4'h2: begin alu_res = opa_q - opb_q; alu_c = (opa_q < opb_q); end
      4'h3: begin alu_res = opa_q & opb_q; alu_c = 1'b0; end
      4'h4: begin alu_res = opa_q | opb_q; alu_c = 1'b0; end
      4'h5: begin alu_res = opa_q ^ opb_q; alu_c = 1'b0; end
      4'h6: begin alu_res = ~opa_q; alu_c = 1'b0; end
      4'h7: begin alu_res = opa_q << opb_q[3:0]; alu_c = 1'b0; end
      4'h8: begin alu_res = opa_q >> opb_q[3:0]; alu_c = 1'b0; end
      4'h9: alu_res = opa_q;
      4'hA: alu_res = {7'b0, ir_q[8:0]};
      4'hB: begin alu_res = addi17[15:0]; alu_c = addi17[16]; end
      default: alu_res = 16'h0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    nz_d     = nz_q;
    nc_d     = nc_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          ir_d    = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d   = rf_rd0_data;
        opb_d   = rf_rd1_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_res;
        nz_d    = (alu_res == 16'h0000);
        nc_d    = alu_c;
        state_d = S_WB;
      end
      S_WB: begin
        if (op_writes) begin
          result_d = res_q;
          flag_z_d = nz_q;
          flag_c_d = nc_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ir_q     <= 16'h0000;
      opa_q    <= 16'h0000;
      opb_q    <= 16'h0000;
      res_q    <= 16'h0000;
      nz_q     <= 1'b0;
      nc_q     <= 1'b0;
      result_q <= 16'h0000;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      nz_q     <= nz_d;
      nc_q     <= nc_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE) && rst;
  assign rf_rd0_addr = ir_q[8:6];
  assign rf_rd1_addr = ir_q[5:3];
  assign rf_wr_addr  = ir_q[11:9];
  assign rf_wr_data  = res_q;
  assign done        = (state_q == S_WB);
  assign err         = done && (op[3:2] == 2'b11);
  assign rf_wr_en    = done && op_writes;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign result      = result_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: behavioural 8x16 register file, reference model feeding a scoreboard queue,
// directed scenarios plus a short random run.
module tb_rf_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_rd0_addr, rf_rd1_addr, rf_wr_addr;
  logic [15:0] rf_rd0_data, rf_rd1_data, rf_wr_data;
  logic        rf_wr_en, done, err, flag_z, flag_c;
  logic [15:0] result;

  rf_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
    .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .done(done), .err(err), .flag_z(flag_z), .flag_c(flag_c), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register file the sequencer drives; cleared by the same reset
  logic [15:0] regs [8];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else if (rf_wr_en) begin
      regs[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd0_data = regs[rf_rd0_addr];
  assign rf_rd1_data = regs[rf_rd1_addr];

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        err;
    logic        z;
    logic        c;
    logic [15:0] result;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] ref_regs [8];
  logic        ref_z, ref_c;
  logic [15:0] ref_result;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
    ref_z = 1'b0;
    ref_c = 1'b0;
    ref_result = 16'h0000;
  endtask

  task automatic model_push(input logic [15:0] ins);
    exp_t e;
    logic [3:0]  op;
    logic [15:0] a, b, r;
    logic [16:0] s;
    logic        c;
    op = ins[15:12];
    a  = ref_regs[ins[8:6]];
    b  = ref_regs[ins[5:3]];
    r  = 16'h0000;
    c  = ref_c;
    case (op)
      4'h1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      4'h2: begin r = a - b; c = (a < b); end
      4'h3: begin r = a & b; c = 1'b0; end
      4'h4: begin r = a | b; c = 1'b0; end
      4'h5: begin r = a ^ b; c = 1'b0; end
      4'h6: begin r = ~a; c = 1'b0; end
      4'h7: begin r = a << b[3:0]; c = 1'b0; end
      4'h8: begin r = a >> b[3:0]; c = 1'b0; end
      4'h9: r = a;
      4'hA: r = {7'b0, ins[8:0]};
      4'hB: begin
        s = {1'b0, a} + {1'b0, {{10{ins[5]}}, ins[5:0]}};
        r = s[15:0];
        c = s[16];
      end
      default: r = 16'h0000;
    endcase
    e.wr   = (op >= 4'h1) && (op <= 4'hB);
    e.addr = ins[11:9];
    e.data = r;
    e.err  = (op >= 4'hC);
    if (e.wr) begin
      ref_regs[ins[11:9]] = r;
      ref_z = (r == 16'h0000);
      ref_c = c;
      ref_result = r;
    end
    e.z = ref_z;
    e.c = ref_c;
    e.result = ref_result;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the WB cycle.
  task automatic exec_instr(input logic [15:0] ins, input string name);
    exp_t e;
    int   n;
    int   stray;
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    model_push(ins);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'($urandom);
    n = 1;
    stray = 0;
    while (!done && n < 10) begin
      if (rf_wr_en) stray++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, expected 3", name, n);
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL %s early_wr_en: got %0d cycles with rf_wr_en before WB, expected 0", name, stray);
    end
    e = exp_q.pop_front();
    vectors++;
    if (rf_wr_en !== e.wr) begin
      miscompares++;
      $display("FAIL %s rf_wr_en: got %b expected %b", name, rf_wr_en, e.wr);
    end
    if (e.wr) begin
      vectors++;
      if (rf_wr_addr !== e.addr || rf_wr_data !== e.data) begin
        miscompares++;
        $display("FAIL %s write: got R%0d=%h expected R%0d=%h", name, rf_wr_addr, rf_wr_data, e.addr, e.data);
      end
    end
    vectors++;
    if (err !== e.err) begin
      miscompares++;
      $display("FAIL %s err: got %b expected %b", name, err, e.err);
    end
    @(negedge clk);
    vectors++;
    if (flag_z !== e.z || flag_c !== e.c || result !== e.result) begin
      miscompares++;
      $display("FAIL %s flags: got z=%b c=%b result=%h expected z=%b c=%b result=%h",
               name, flag_z, flag_c, result, e.z, e.c, e.result);
    end
    vectors++;
    if (done !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after_wb: got done=%b err=%b ready=%b expected 0 0 1", name, done, err, instr_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    #3 rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_low: got %b expected 0", instr_ready);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b1 || rf_wr_en !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        flag_z !== 1'b0 || flag_c !== 1'b0 || result !== 16'h0000 || rf_wr_data !== 16'h0000 ||
        rf_rd0_addr !== 3'd0 || rf_rd1_addr !== 3'd0 || rf_wr_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b wr_en=%b done=%b err=%b z=%b c=%b result=%h wdata=%h expected 1,0,0,0,0,0,0000,0000",
               instr_ready, rf_wr_en, done, err, flag_z, flag_c, result, rf_wr_data);
    end
    @(negedge clk);
  endtask

  task automatic test_nop();
    exec_instr(16'h0000, "nop");
  endtask

  task automatic test_li_add();
    exec_instr({4'hA, 3'd1, 9'h1FF}, "li_r1_1ff");
    exec_instr({4'hA, 3'd2, 9'h001}, "li_r2_001");
    exec_instr({4'h1, 3'd3, 3'd1, 3'd2, 3'd0}, "add_r3");
    vectors++;
    if (regs[3] !== 16'h0200) begin
      miscompares++;
      $display("FAIL add_r3_regfile: got %h expected 0200", regs[3]);
    end
  endtask

  task automatic test_sub_xor();
    exec_instr({4'hA, 3'd1, 9'h000}, "li_r1_0");
    exec_instr({4'h2, 3'd4, 3'd1, 3'd2, 3'd0}, "sub_borrow");
    exec_instr({4'h5, 3'd5, 3'd4, 3'd4, 3'd0}, "xor_zero");
  endtask

  task automatic test_addi_sll();
    exec_instr({4'hB, 3'd6, 3'd6, 6'h3F}, "addi_minus1");
    exec_instr({4'hA, 3'd1, 9'h00F}, "li_r1_15");
    exec_instr({4'h7, 3'd7, 3'd2, 3'd1, 3'd0}, "sll_15");
  endtask

  task automatic test_illegal();
    exec_instr({4'hE, 3'd3, 3'd1, 3'd2, 3'd0}, "illegal_e");
    exec_instr({4'hC, 3'd0, 9'h1AB}, "illegal_c");
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    int   acc [3];
    int   idx, ndone, n;
    exp_t e;
    prog[0] = {4'h6, 3'd0, 3'd7, 3'd0, 3'd0};
    prog[1] = {4'h8, 3'd1, 3'd7, 3'd1, 3'd0};
    prog[2] = {4'h9, 3'd2, 3'd0, 3'd0, 3'd0};
    idx = 0;
    ndone = 0;
    n = 0;
    instr_valid = 1'b0;
    while (ndone < 3 && n < 60) begin
      if (done) begin
        e = exp_q.pop_front();
        vectors++;
        if (rf_wr_en !== e.wr || rf_wr_addr !== e.addr || rf_wr_data !== e.data || err !== e.err) begin
          miscompares++;
          $display("FAIL b2b_write%0d: got en=%b R%0d=%h err=%b expected en=%b R%0d=%h err=%b",
                   ndone, rf_wr_en, rf_wr_addr, rf_wr_data, err, e.wr, e.addr, e.data, e.err);
        end
        ndone++;
      end
      if (instr_ready) begin
        if (idx < 3) begin
          instr = prog[idx];
          instr_valid = 1'b1;
          model_push(prog[idx]);
          acc[idx] = cyc;
          idx++;
        end else begin
          instr_valid = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    vectors++;
    if (ndone !== 3) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d completions expected 3", ndone);
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (acc[i] - acc[i-1] !== 4) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d: got %0d cycles expected 4", i, acc[i] - acc[i-1]);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (result !== ref_result || flag_z !== ref_z || flag_c !== ref_c) begin
      miscompares++;
      $display("FAIL b2b_flags: got result=%h z=%b c=%b expected %h %b %b",
               result, flag_z, flag_c, ref_result, ref_z, ref_c);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) exec_instr(16'($urandom), "random");
    for (int r = 0; r < 8; r++) begin
      vectors++;
      if (regs[r] !== ref_regs[r]) begin
        miscompares++;
        $display("FAIL random_regfile R%0d: got %h expected %h", r, regs[r], ref_regs[r]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    exec_instr({4'hA, 3'd3, 9'h123}, "pre_abort_li");
    instr = {4'h1, 3'd4, 3'd3, 3'd3, 3'd0};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (instr_ready !== 1'b0 || rf_wr_en !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        flag_z !== 1'b0 || flag_c !== 1'b0 || result !== 16'h0000 || rf_wr_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_outputs: got ready=%b wr_en=%b done=%b err=%b z=%b c=%b result=%h wdata=%h expected all 0",
               instr_ready, rf_wr_en, done, err, flag_z, flag_c, result, rf_wr_data);
    end
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (rf_wr_en || done) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL abort_no_wb: got %0d cycles with write/done expected 0", n);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b1 || regs[3] !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_release: got ready=%b R3=%h expected 1 0000", instr_ready, regs[3]);
    end
    @(negedge clk);
    exec_instr({4'hA, 3'd3, 9'h055}, "post_abort_li");
    exec_instr({4'h1, 3'd4, 3'd3, 3'd1, 3'd0}, "post_abort_add");
  endtask

  initial begin
    test_reset();
    test_nop();
    test_li_add();
    test_sub_xor();
    test_addi_sll();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
